// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states and write-data owner encoding.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_WRDATA = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } wr_owner_e;

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// Starvation counter for the DM port arbiter; forces a host slot after STARVE_MAX denied cycles.
// Only compiled into the design when DM_ARB_STARVE_EN is defined.
`ifdef DM_ARB_STARVE_EN
module dm_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pend,
  input  logic i_core_req,
  input  logic i_host_issue,
  output logic o_force
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_cnt;

  assign o_force = i_pend && i_core_req && (r_cnt == CW'(STARVE_MAX));

  // A forced slot is itself a host issue, so the counter clears on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_host_issue) begin
      r_cnt <= '0;
    end else if (i_pend && i_core_req) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/dm_port_arbiter.sv
// Shares the single DM port between the core pipeline and a host/debug requester.
// Optional starvation guard enabled with `define DM_ARB_STARVE_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned DMA_SIZE   = 17,
  parameter int unsigned DMD_SIZE   = 16,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps_dm_cslt,
  input  logic                ps_dm_wrb,
  input  logic [DMA_SIZE-1:0] dg_dm_add,
  input  logic [DMD_SIZE-1:0] bc_dt,
  output logic                core_dm_stall,
  input  logic                hst_req,
  input  logic                hst_wrb,
  input  logic [DMA_SIZE-1:0] hst_add,
  input  logic [DMD_SIZE-1:0] hst_wdata,
  output logic                hst_gnt,
  output logic                hst_rvalid,
  output logic [DMD_SIZE-1:0] hst_rdata,
  output logic                arb_dm_cslt,
  output logic                arb_dm_wrb,
  output logic [DMA_SIZE-1:0] arb_dm_add,
  output logic [DMD_SIZE-1:0] arb_dm_wdata,
  input  logic [DMD_SIZE-1:0] mem_dm_rdata
);

  if (STARVE_MAX == 0) begin : g_bad_starve_max
    $error("dm_port_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_e          r_state, w_state_nxt;
  logic                r_hold_wrb;
  logic [DMA_SIZE-1:0] r_hold_add;
  logic [DMD_SIZE-1:0] r_hold_wdata;
  wr_owner_e           r_wr_owner;
  logic                r_hst_rvalid;
  logic [DMD_SIZE-1:0] r_hst_rdata;

  logic w_pend;
  logic w_force;
  logic w_host_issue;
  logic w_core_fwd;

  assign w_pend = (r_state == ST_PEND);

`ifdef DM_ARB_STARVE_EN
  dm_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk          (clk),
    .rst          (rst),
    .i_pend       (w_pend),
    .i_core_req   (ps_dm_cslt),
    .i_host_issue (w_host_issue),
    .o_force      (w_force)
  );
`else
  assign w_force = 1'b0;
`endif

  assign w_host_issue  = w_pend && (!ps_dm_cslt || w_force);
  assign w_core_fwd    = ps_dm_cslt && !w_force;
  assign core_dm_stall = w_force;
  assign hst_gnt       = (r_state == ST_IDLE) && hst_req;
  assign hst_rvalid    = r_hst_rvalid;
  assign hst_rdata     = r_hst_rdata;

  // Write data trails its issue by one cycle, so the mux follows last cycle's writer.
  assign arb_dm_wdata  = (r_wr_owner == OWN_HOST) ? r_hold_wdata : bc_dt;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    arb_dm_cslt = 1'b0;
    arb_dm_wrb  = 1'b0;
    arb_dm_add  = '0;

    if (w_host_issue) begin
      arb_dm_cslt = 1'b1;
      arb_dm_wrb  = r_hold_wrb;
      arb_dm_add  = r_hold_add;
    end else if (w_core_fwd) begin
      arb_dm_cslt = 1'b1;
      arb_dm_wrb  = ps_dm_wrb;
      arb_dm_add  = dg_dm_add;
    end

    case (r_state)
      ST_IDLE:   if (hst_req) w_state_nxt = ST_PEND;
      ST_PEND:   if (w_host_issue) w_state_nxt = r_hold_wrb ? ST_WRDATA : ST_RDWAIT;
      ST_RDWAIT: w_state_nxt = ST_IDLE;
      ST_WRDATA: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_wrb   <= 1'b0;
      r_hold_add   <= '0;
      r_hold_wdata <= '0;
      r_wr_owner   <= OWN_CORE;
      r_hst_rvalid <= 1'b0;
      r_hst_rdata  <= '0;
    end else begin
      r_hst_rvalid <= (r_state == ST_RDWAIT);
      r_wr_owner   <= (w_host_issue && r_hold_wrb) ? OWN_HOST : OWN_CORE;
      if (r_state == ST_RDWAIT) begin
        r_hst_rdata <= mem_dm_rdata;
      end
      if (hst_gnt) begin
        r_hold_wrb   <= hst_wrb;
        r_hold_add   <= hst_add;
        r_hold_wdata <= hst_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small behavioural DM (write lands at issue+1).
module tb_dm_port_arbiter;

  localparam int unsigned DMA = 17;
  localparam int unsigned DMD = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           ps_dm_cslt, ps_dm_wrb;
  logic [DMA-1:0] dg_dm_add;
  logic [DMD-1:0] bc_dt;
  logic           core_dm_stall;
  logic           hst_req, hst_wrb;
  logic [DMA-1:0] hst_add;
  logic [DMD-1:0] hst_wdata;
  logic           hst_gnt, hst_rvalid;
  logic [DMD-1:0] hst_rdata;
  logic           arb_dm_cslt, arb_dm_wrb;
  logic [DMA-1:0] arb_dm_add;
  logic [DMD-1:0] arb_dm_wdata;
  logic [DMD-1:0] mem_dm_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(
    .DMA_SIZE   (DMA),
    .DMD_SIZE   (DMD),
    .STARVE_MAX (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ps_dm_cslt    (ps_dm_cslt),
    .ps_dm_wrb     (ps_dm_wrb),
    .dg_dm_add     (dg_dm_add),
    .bc_dt         (bc_dt),
    .core_dm_stall (core_dm_stall),
    .hst_req       (hst_req),
    .hst_wrb       (hst_wrb),
    .hst_add       (hst_add),
    .hst_wdata     (hst_wdata),
    .hst_gnt       (hst_gnt),
    .hst_rvalid    (hst_rvalid),
    .hst_rdata     (hst_rdata),
    .arb_dm_cslt   (arb_dm_cslt),
    .arb_dm_wrb    (arb_dm_wrb),
    .arb_dm_add    (arb_dm_add),
    .arb_dm_wdata  (arb_dm_wdata),
    .mem_dm_rdata  (mem_dm_rdata)
  );

  // Behavioural DM: read data the cycle after issue, write data taken at issue+1.
  logic [DMD-1:0] mem [0:255];
  logic [7:0]     m_radd, m_wadd;
  logic           m_wr;

  assign mem_dm_rdata = mem[m_radd];

  always @(posedge clk) begin
    if (rst) begin
      mem[8'h05] <= 16'h1234;
      mem[8'h20] <= 16'h5A5A;
      mem[8'h30] <= 16'hC3C3;
      m_radd     <= 8'h05;
      m_wadd     <= 8'h00;
      m_wr       <= 1'b0;
    end else begin
      m_wr <= arb_dm_cslt && arb_dm_wrb;
      if (arb_dm_cslt && !arb_dm_wrb) m_radd <= arb_dm_add[7:0];
      if (arb_dm_cslt &&  arb_dm_wrb) m_wadd <= arb_dm_add[7:0];
      if (m_wr) mem[m_wadd] <= arb_dm_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit seen;

    rst = 1'b1;
    ps_dm_cslt = 1'b0; ps_dm_wrb = 1'b0; dg_dm_add = '0; bc_dt = '0;
    hst_req = 1'b0; hst_wrb = 1'b0; hst_add = '0; hst_wdata = '0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_gnt",    32'(hst_gnt),       32'h0);
    check("rst_rvalid", 32'(hst_rvalid),    32'h0);
    check("rst_stall",  32'(core_dm_stall), 32'h0);
    check("rst_cslt",   32'(arb_dm_cslt),   32'h0);
    check("rst_rdata",  32'(hst_rdata),     32'h0);
    tick();
    rst = 1'b0;

    // 1: host read of 0x00005 with the core idle
    tick();
    hst_req = 1'b1; hst_wrb = 1'b0; hst_add = 17'h00005;
    #1 check("t1_gnt", 32'(hst_gnt), 32'h1);
    tick();
    hst_req = 1'b0;
    #1 check("t1_iss_cslt", 32'(arb_dm_cslt), 32'h1);
    check("t1_iss_wrb", 32'(arb_dm_wrb), 32'h0);
    check("t1_iss_add", 32'(arb_dm_add), 32'h00005);
    check("t1_gnt_off", 32'(hst_gnt),    32'h0);
    tick();
    #1 check("t1_rv_early", 32'(hst_rvalid), 32'h0);
    tick();
    #1 check("t1_rvalid", 32'(hst_rvalid), 32'h1);
    check("t1_rdata", 32'(hst_rdata), 32'h1234);
    tick();
    #1 check("t1_rv_pulse", 32'(hst_rvalid), 32'h0);
    check("t1_rdata_hold", 32'(hst_rdata), 32'h1234);

    // 2: host write 0x0000A/0xBEEF, then a core read of the same address
    hst_req = 1'b1; hst_wrb = 1'b1; hst_add = 17'h0000A; hst_wdata = 16'hBEEF;
    #1 check("t2_gnt", 32'(hst_gnt), 32'h1);
    tick();
    hst_req = 1'b0; hst_wdata = 16'h0000;
    #1 check("t2_iss_wrb", 32'(arb_dm_wrb), 32'h1);
    check("t2_iss_add", 32'(arb_dm_add), 32'h0000A);
    tick();
    #1 check("t2_wdata", 32'(arb_dm_wdata), 32'hBEEF);
    tick();
    ps_dm_cslt = 1'b1; ps_dm_wrb = 1'b0; dg_dm_add = 17'h0000A;
    #1 check("t2_core_fwd_add", 32'(arb_dm_add), 32'h0000A);
    tick();
    ps_dm_cslt = 1'b0;
    #1 check("t2_core_rd", 32'(mem_dm_rdata), 32'hBEEF);

    // 3: core write and host write accepted together; data phases must not cross
    tick();
    hst_req = 1'b1; hst_wrb = 1'b1; hst_add = 17'h0000C; hst_wdata = 16'h2222;
    ps_dm_cslt = 1'b1; ps_dm_wrb = 1'b1; dg_dm_add = 17'h0000B; bc_dt = 16'h0000;
    #1 check("t3_gnt", 32'(hst_gnt), 32'h1);
    check("t3_core_add", 32'(arb_dm_add), 32'h0000B);
    tick();
    hst_req = 1'b0; ps_dm_cslt = 1'b0; ps_dm_wrb = 1'b0; bc_dt = 16'h1111;
    #1 check("t3_wdata_core", 32'(arb_dm_wdata), 32'h1111);
    check("t3_host_add", 32'(arb_dm_add), 32'h0000C);
    tick();
    bc_dt = 16'h0000;
    #1 check("t3_wdata_host", 32'(arb_dm_wdata), 32'h2222);
    tick();
    ps_dm_cslt = 1'b1; dg_dm_add = 17'h0000B;
    tick();
    ps_dm_cslt = 1'b0;
    #1 check("t3_core_rd", 32'(mem_dm_rdata), 32'h1111);

    // 4: host read pending while the core reads every cycle
    tick();
    hst_req = 1'b1; hst_wrb = 1'b0; hst_add = 17'h00020;
    ps_dm_cslt = 1'b1; ps_dm_wrb = 1'b0; dg_dm_add = 17'h00010;
    #1 check("t4_gnt", 32'(hst_gnt), 32'h1);
    tick();
    hst_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
`ifdef DM_ARB_STARVE_EN
      #1 check($sformatf("t4_stall_%0d", i), 32'(core_dm_stall), (i == 4) ? 32'h1 : 32'h0);
      check($sformatf("t4_add_%0d", i), 32'(arb_dm_add), (i == 4) ? 32'h00020 : 32'h00010);
`else
      #1 check($sformatf("t4_stall_%0d", i), 32'(core_dm_stall), 32'h0);
      check($sformatf("t4_add_%0d", i), 32'(arb_dm_add), 32'h00010);
`endif
      tick();
    end
    ps_dm_cslt = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1 if (hst_rvalid) seen = 1'b1;
      else tick();
    end
    check("t4_rvalid_seen", 32'(seen), 32'h1);
    check("t4_rdata", 32'(hst_rdata), 32'h5A5A);
    tick();

    // 5: reset while waiting for read data
    hst_req = 1'b1; hst_wrb = 1'b0; hst_add = 17'h00030;
    tick();
    hst_req = 1'b0;
    tick();
    rst = 1'b1;
    #1 check("t5_cslt", 32'(arb_dm_cslt), 32'h0);
    check("t5_rvalid", 32'(hst_rvalid), 32'h0);
    check("t5_rdata",  32'(hst_rdata),  32'h0);
    check("t5_stall",  32'(core_dm_stall), 32'h0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (hst_rvalid) seen = 1'b1;
    end
    check("t5_no_rvalid", 32'(seen), 32'h0);

    // 6: hst_req held for two reads; second grant coincides with the first rvalid
    hst_req = 1'b1; hst_wrb = 1'b0; hst_add = 17'h00005;
    #1 check("t6_gnt_a", 32'(hst_gnt), 32'h1);
    tick();
    #1 check("t6_gnt_p1", 32'(hst_gnt), 32'h0);
    tick();
    #1 check("t6_gnt_p2", 32'(hst_gnt), 32'h0);
    tick();
    #1 check("t6_rvalid_a", 32'(hst_rvalid), 32'h1);
    check("t6_gnt_b", 32'(hst_gnt), 32'h1);
    tick();
    hst_req = 1'b0;
    #1 check("t6_gnt_off", 32'(hst_gnt), 32'h0);
    tick();
    tick();
    #1 check("t6_rvalid_b", 32'(hst_rvalid), 32'h1);
    check("t6_rdata_b", 32'(hst_rdata), 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
